// File: rtl/carfield_regbus_map_pkg.sv
// Carfield RegBus peripheral map: target indices, region bases/sizes, demux FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package carfield_regbus_map_pkg;

  // 64-bit platform address/config word, as used by the platform configuration constants.
  typedef logic [63:0] doub_bt;

  localparam int unsigned NumTargets = 4;

  typedef enum logic [1:0] {
    TgtPcrs     = 2'd0,
    TgtPll      = 2'd1,
    TgtPadframe = 2'd2,
    TgtL2Ecc    = 2'd3
  } tgt_idx_e;

  localparam doub_bt PcrsBase     = 64'h0000_0000_2001_0000;
  localparam doub_bt PllBase      = 64'h0000_0000_2002_0000;
  localparam doub_bt PadframeBase = 64'h0000_0000_200A_0000;
  localparam doub_bt L2EccBase    = 64'h0000_0000_200B_0000;
  localparam doub_bt RegionSize   = 64'h0000_0000_0000_1000;

  // Indexed by tgt_idx_e.
  localparam doub_bt TgtBase [NumTargets] = '{PcrsBase, PllBase, PadframeBase, L2EccBase};
  localparam doub_bt TgtSize [NumTargets] = '{RegionSize, RegionSize, RegionSize, RegionSize};

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StResp   = 2'd2
  } state_e;

endpackage

// File: rtl/carfield_regbus_addr_decode.sv
// Combinational address decoder for the RegBus peripheral region.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows addr/enable every cycle.
// Ports: addr (absolute), en (per-target enable) -> hit, idx (target), offset (addr - base).
module carfield_regbus_addr_decode
  import carfield_regbus_map_pkg::*;
#(
  parameter int unsigned AddrWidth = 48
) (
  input  logic [AddrWidth-1:0]  addr,
  input  logic [NumTargets-1:0] en,
  output logic                  hit,
  output tgt_idx_e              idx,
  output logic [AddrWidth-1:0]  offset
);

  always_comb begin
    hit    = 1'b0;
    idx    = TgtPcrs;
    offset = '0;
    // Regions do not overlap, so first-match priority only matters for robustness.
    for (int unsigned i = 0; i < NumTargets; i++) begin
      if (!hit && en[i] &&
          (addr >= AddrWidth'(TgtBase[i])) &&
          (addr <  AddrWidth'(TgtBase[i] + TgtSize[i]))) begin
        hit    = 1'b1;
        idx    = tgt_idx_e'(i);
        offset = addr - AddrWidth'(TgtBase[i]);
      end
    end
  end

endmodule

// File: rtl/carfield_regbus_periph_demux.sv
// Single-outstanding RegBus demux onto PCRS/PLL/Padframe/L2Ecc register files.
// Latency: accept at cycle 0, target select at cycle 1, response at cycle 2 minimum.
// Backpressure: one access in flight; req_ready_o low from accept until the response is consumed.
// Ports: req_* upstream request, rsp_* upstream response, tgt_* per-target request/response,
//        timeout_o abort pulse, err_count_o saturating count of decode misses plus timeouts.
module carfield_regbus_periph_demux #(
  parameter int unsigned                 AddrWidth     = 48,
  parameter int unsigned                 DataWidth     = 32,
  parameter int unsigned                 NumTargets    = carfield_regbus_map_pkg::NumTargets,
  parameter logic [NumTargets-1:0]       TargetEnable  = 4'b1111,
  parameter int unsigned                 TimeoutCycles = 255
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              req_valid_i,
  output logic                              req_ready_o,
  input  logic [AddrWidth-1:0]              req_addr_i,
  input  logic                              req_write_i,
  input  logic [DataWidth-1:0]              req_wdata_i,
  input  logic [DataWidth/8-1:0]            req_wstrb_i,
  output logic                              rsp_valid_o,
  input  logic                              rsp_ready_i,
  output logic [DataWidth-1:0]              rsp_rdata_o,
  output logic                              rsp_error_o,
  output logic [NumTargets-1:0]             tgt_valid_o,
  output logic [AddrWidth-1:0]              tgt_addr_o,
  output logic                              tgt_write_o,
  output logic [DataWidth-1:0]              tgt_wdata_o,
  output logic [DataWidth/8-1:0]            tgt_wstrb_o,
  input  logic [NumTargets-1:0]             tgt_ready_i,
  input  logic [NumTargets*DataWidth-1:0]   tgt_rdata_i,
  input  logic [NumTargets-1:0]             tgt_error_i,
  output logic                              timeout_o,
  output logic [15:0]                       err_count_o
);

  import carfield_regbus_map_pkg::*;

  state_e         state_q;
  tgt_idx_e       sel_q;
  logic [15:0]    to_cnt_q;

  logic                 dec_hit;
  tgt_idx_e             dec_idx;
  logic [AddrWidth-1:0] dec_offset;

  logic                 sel_ready;
  logic                 sel_error;
  logic [DataWidth-1:0] sel_rdata;
  logic                 to_expire;

  carfield_regbus_addr_decode #(
    .AddrWidth (AddrWidth)
  ) i_addr_decode (
    .addr   (req_addr_i),
    .en     (TargetEnable),
    .hit    (dec_hit),
    .idx    (dec_idx),
    .offset (dec_offset)
  );

  // Only the selected target's handshake is observed; other ready/error bits are don't-care.
  assign sel_ready = tgt_ready_i[sel_q];
  assign sel_error = tgt_error_i[sel_q];
  assign sel_rdata = tgt_rdata_i[int'(sel_q)*DataWidth +: DataWidth];

  assign to_expire = (TimeoutCycles != 0) && (to_cnt_q == 16'(TimeoutCycles));

  // Combinational so the pulse lines up with the ACCESS cycle that aborts;
  // a same-cycle ready suppresses it.
  assign timeout_o = (state_q == StAccess) && !sel_ready && to_expire;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      sel_q       <= TgtPcrs;
      to_cnt_q    <= '0;
      req_ready_o <= 1'b1;
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= '0;
      rsp_error_o <= 1'b0;
      tgt_valid_o <= '0;
      tgt_addr_o  <= '0;
      tgt_write_o <= 1'b0;
      tgt_wdata_o <= '0;
      tgt_wstrb_o <= '0;
      err_count_o <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (req_valid_i) begin
            req_ready_o <= 1'b0;
            tgt_addr_o  <= dec_offset;
            tgt_write_o <= req_write_i;
            tgt_wdata_o <= req_wdata_i;
            tgt_wstrb_o <= req_wstrb_i;
            sel_q       <= dec_idx;
            to_cnt_q    <= '0;
            if (dec_hit) begin
              state_q     <= StAccess;
              tgt_valid_o <= NumTargets'(1) << dec_idx;
            end else begin
              state_q     <= StResp;
              rsp_valid_o <= 1'b1;
              rsp_rdata_o <= '0;
              rsp_error_o <= 1'b1;
              if (err_count_o != 16'hFFFF) err_count_o <= err_count_o + 16'd1;
            end
          end
        end

        StAccess: begin
          if (sel_ready) begin
            state_q     <= StResp;
            tgt_valid_o <= '0;
            rsp_valid_o <= 1'b1;
            // Writes never return target data.
            rsp_rdata_o <= tgt_write_o ? '0 : sel_rdata;
            rsp_error_o <= sel_error;
          end else if (to_expire) begin
            state_q     <= StResp;
            tgt_valid_o <= '0;
            rsp_valid_o <= 1'b1;
            rsp_rdata_o <= '0;
            rsp_error_o <= 1'b1;
            if (err_count_o != 16'hFFFF) err_count_o <= err_count_o + 16'd1;
          end else if (TimeoutCycles != 0) begin
            to_cnt_q <= to_cnt_q + 16'd1;
          end
        end

        StResp: begin
          if (rsp_ready_i) begin
            state_q     <= StIdle;
            rsp_valid_o <= 1'b0;
            req_ready_o <= 1'b1;
          end
        end

        default: begin
          state_q     <= StIdle;
          tgt_valid_o <= '0;
          rsp_valid_o <= 1'b0;
          req_ready_o <= 1'b1;
        end
      endcase
    end
  end

endmodule
